controller_rom1_loader: RTL and testbench
=========================================

// Module: controller_rom1_loader
// PURPOSE
//  Upstream write-feeder for the controller ROM1 byte-lane RAM. Takes a host byte
//  stream (SPI/IO upload, valid/ready), packs bytes big-endian into 32-bit words and
//  drives the RAM's we/bytesel/addr/d port. Defers every write while the controller
//  CPU owns the port. Partial final words are written with only the filled lanes enabled.
// PARAMETERS
//  ADDR_WIDTH  15  word-address width; must match the downstream RAM
// PORTS
//  clk         in   1           system clock; the block's single clock
//  reset_n     in   1           asynchronous active-low reset
//  start       in   1           1-cycle pulse: begin an upload at base_addr (IDLE only)
//  base_addr   in   ADDR_WIDTH  first word address of the upload
//  byte_valid  in   1           byte_data/byte_last valid
//  byte_data   in   8           stream byte
//  byte_last   in   1           final byte of the stream, qualified by byte_valid
//  byte_ready  out  1           byte accepted on a cycle where byte_valid & byte_ready
//  cpu_busy    in   1           CPU owns the RAM port this cycle; loader must not write
//  we          out  1           RAM write strobe, exactly one cycle per word
//  bytesel     out  4           lane enables; bit k enables d[31-8k -: 8]
//  addr        out  ADDR_WIDTH  RAM word address
//  d           out  32          RAM write data
//  busy        out  1           high from accepted start until the done pulse
//  done        out  1           1-cycle pulse after the final write
//  overflow    out  1           sticky: bytes arrived after the top word was written; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lane counter 0, word buffer 0.
//  States: IDLE -> COLLECT on start (addr<=base_addr, lane<=0, overflow<=0).
//   COLLECT: byte_ready=1. An accepted byte goes to lane `lane` (first byte -> d[31:24]);
//    its bytesel bit is set and lane increments. Move to WRITE on the 4th byte or on byte_last.
//   WRITE: byte_ready=0. If cpu_busy=0, assert we for one cycle with the buffered
//    d/bytesel (4'b1111 for a full word, e.g. 4'b0011 for a two-byte tail); else hold.
//    After the write: clear buffer/bytesel, lane<=0.
//    If the write was the last word, go to DONE; else addr+1 and return to COLLECT.
//    If addr was all-ones, go to FULL; addr does not wrap.
//   FULL: byte_ready=1; accepted bytes are discarded and set overflow; byte_last -> DONE.
//   DONE: done=1 for one cycle, busy drops in the same cycle; then IDLE.
//  Latency: the completing byte is accepted in cycle N; we is asserted in N+1 when
//   cpu_busy=0, or in the first cycle after cpu_busy falls.
//  When we=0, bytesel/d are 0, so the RAM mux can OR-combine them with the CPU side.
//  start outside IDLE is ignored. byte_valid in IDLE/DONE is not accepted (byte_ready=0).
//  byte_last on a lane-0 boundary with no new byte cannot occur; byte_last is only
//   meaningful with byte_valid.
//  Reset asserted mid-upload aborts immediately with no partial write; the RAM content
//   written so far remains.
// STRUCTURE
//  Shared package (controller_pkg): state encoding localparams {IDLE,COLLECT,WRITE,FULL,DONE};
//   lane-to-bit-range constant (lane k -> [31-8k -: 8]), which the CPU bus mux shares.
//  Single flat module; no sub-module is warranted. The 4-byte packer is inline.
// TESTING
//  1. start base=0x0010, bytes 11 22 33 44 (last on 44), cpu_busy=0 ->
//     one we at addr 0x0010, d=0x11223344, bytesel=1111; done one cycle later.
//  2. 6 bytes AA..FF, last on FF -> word 0x0010=AABBCCDD (1111);
//     word 0x0011=EEFF0000, bytesel=0011; exactly 2 we pulses.
//  3. cpu_busy held high 5 cycles when a word completes -> we delayed to the cycle
//     after cpu_busy falls; byte_ready low throughout; d unchanged.
//  4. base = all-ones, 8 bytes -> one write at top address; remaining 4 bytes dropped;
//     overflow=1; done on last; a new start clears overflow.
//  5. reset_n pulled low after 2 bytes of a word -> no we, all outputs 0 asynchronously;
//     a fresh upload afterwards behaves as in test 1.
//  6. start pulsed while busy, or byte_valid in IDLE -> ignored; addr and RAM untouched.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the controller ROM1 port: loader state encoding and
// the byte-lane to data-bit mapping that the CPU bus mux also uses.
package controller_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_FULL    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int LANE_BITS = 8;
  localparam int LANES     = 4;

  // Lane k occupies d[31-8k -: 8]; this returns the low bit of that range.
  function automatic logic [4:0] lane_lsb(input logic [1:0] k);
    return 5'd24 - {k, 3'b000};
  endfunction

endpackage

// File: rtl/controller_rom1_loader.sv
// Packs a host byte stream big-endian into 32-bit words and writes them into the
// ROM1 byte-lane RAM, yielding the port whenever the controller CPU owns it.
module controller_rom1_loader
  import controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  input  logic                  cpu_busy,
  output logic                  we,
  output logic [3:0]            bytesel,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           d,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  logic [2:0]            state_reg;
  logic [1:0]            lane_reg;
  logic                  last_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           word_reg;
  logic [3:0]            sel_reg;
  logic                  overflow_reg;
  logic                  accept;

  assign byte_ready = (state_reg == ST_COLLECT) || (state_reg == ST_FULL);
  assign accept     = byte_valid && byte_ready;
  assign we         = (state_reg == ST_WRITE) && !cpu_busy;
  assign busy       = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE) ||
                      (state_reg == ST_FULL);
  assign done       = (state_reg == ST_DONE);
  assign addr       = addr_reg;
  assign overflow   = overflow_reg;

  // Zero data/lanes outside a write so the RAM side can OR this with the CPU bus.
  assign d       = we ? word_reg : 32'd0;
  assign bytesel = we ? sel_reg : 4'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      lane_reg     <= 2'd0;
      last_reg     <= 1'b0;
      addr_reg     <= '0;
      word_reg     <= 32'd0;
      sel_reg      <= 4'd0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_COLLECT;
            addr_reg     <= base_addr;
            lane_reg     <= 2'd0;
            last_reg     <= 1'b0;
            word_reg     <= 32'd0;
            sel_reg      <= 4'd0;
            overflow_reg <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            word_reg[lane_lsb(lane_reg) +: LANE_BITS] <= byte_data;
            sel_reg[lane_reg] <= 1'b1;
            lane_reg          <= lane_reg + 2'd1;
            if (lane_reg == 2'd3 || byte_last) begin
              state_reg <= ST_WRITE;
              last_reg  <= byte_last;
            end
          end
        end
        ST_WRITE: begin
          if (!cpu_busy) begin
            word_reg <= 32'd0;
            sel_reg  <= 4'd0;
            lane_reg <= 2'd0;
            if (last_reg) begin
              state_reg <= ST_DONE;
            end else if (&addr_reg) begin
              // Top word written: no wrap, swallow the rest of the stream.
              state_reg <= ST_FULL;
            end else begin
              addr_reg  <= addr_reg + 1'b1;
              state_reg <= ST_COLLECT;
            end
          end
        end
        ST_FULL: begin
          if (accept) begin
            overflow_reg <= 1'b1;
            if (byte_last) state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_rom1_loader.sv
// Directed bench for controller_rom1_loader: expected RAM writes are queued as
// stimulus is driven and compared by a monitor whenever the loader strobes we.
module tb_controller_rom1_loader;

  localparam int AW = 15;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   data;
    logic [3:0]    sel;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_last;
  logic          byte_ready;
  logic          cpu_busy;
  logic          we;
  logic [3:0]    bytesel;
  logic [AW-1:0] addr;
  logic [31:0]   d;
  logic          busy;
  logic          done;
  logic          overflow;

  int  checks   = 0;
  int  failures = 0;
  int  we_count = 0;
  wr_t exp_q[$];

  controller_rom1_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .cpu_busy(cpu_busy), .we(we), .bytesel(bytesel),
    .addr(addr), .d(d), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pop one expected word per we pulse; check OR-safe zeros otherwise.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (we === 1'b1) begin
        we_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_we", {49'd0, addr}, 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {49'd0, addr}, {49'd0, e.a});
          check("wr_data", {32'd0, d}, {32'd0, e.data});
          check("wr_sel", {60'd0, bytesel}, {60'd0, e.sel});
          $display("write addr=%0h d=%08h bytesel=%04b", addr, d, bytesel);
        end
      end else begin
        check("idle_zero", {28'd0, bytesel, d}, 64'd0);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] a);
    start = 1'b1;
    base_addr = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("byte_accept_timeout", {63'd0, got}, 64'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    $display("done busy=%0b overflow=%0b", busy, overflow);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; byte_valid = 1'b0;
    byte_data = 8'd0; byte_last = 1'b0; cpu_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {46'd0, we, bytesel, busy, done, overflow, byte_ready, addr}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: single full word, we in the cycle after the completing byte.
    exp_q.push_back('{a: 15'h0010, data: 32'h11223344, sel: 4'b1111});
    w0 = we_count;
    do_start(15'h0010);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    check("t1_latency_we", {63'd0, we}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("t1_done_next", {62'd0, done, busy}, 64'd2);
    @(posedge clk);
    #1;
    check("t1_we_count", we_count - w0, 1);

    // Test 2: full word plus two-byte tail.
    exp_q.push_back('{a: 15'h0010, data: 32'hAABBCCDD, sel: 4'b1111});
    exp_q.push_back('{a: 15'h0011, data: 32'hEEFF0000, sel: 4'b0011});
    w0 = we_count;
    do_start(15'h0010);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_done();
    check("t2_we_count", we_count - w0, 2);

    // Test 3: CPU holds the port for 5 cycles when the word completes.
    exp_q.push_back('{a: 15'h0020, data: 32'h01020304, sel: 4'b1111});
    w0 = we_count;
    do_start(15'h0020);
    cpu_busy = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t3_held_we_ready", {62'd0, we, byte_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    cpu_busy = 1'b0;
    #1;
    check("t3_we_after_release", {63'd0, we}, 64'd1);
    wait_done();
    check("t3_we_count", we_count - w0, 1);

    // Test 4: top address, extra bytes dropped and flagged.
    exp_q.push_back('{a: 15'h7FFF, data: 32'h10111213, sel: 4'b1111});
    w0 = we_count;
    do_start(15'h7FFF);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(i);
      send_byte(b, i == 7);
      if (i == 4) check("t4_overflow_set", {63'd0, overflow}, 64'd1);
    end
    wait_done();
    check("t4_overflow_sticky", {63'd0, overflow}, 64'd1);
    check("t4_addr_no_wrap", {49'd0, addr}, 64'h7FFF);
    check("t4_we_count", we_count - w0, 1);
    exp_q.push_back('{a: 15'h0040, data: 32'h55000000, sel: 4'b0001});
    do_start(15'h0040);
    check("t4_start_clears_ovf", {63'd0, overflow}, 64'd0);
    send_byte(8'h55, 1'b1);
    wait_done();

    // Test 5: reset mid-word aborts without a write.
    w0 = we_count;
    do_start(15'h0050);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_outputs", {46'd0, we, bytesel, busy, done, overflow, byte_ready, addr}, 64'd0);
    check("t5_async_d", {32'd0, d}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_no_we", we_count - w0, 0);
    exp_q.push_back('{a: 15'h0010, data: 32'h11223344, sel: 4'b1111});
    do_start(15'h0010);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    check("t5_latency_we", {63'd0, we}, 64'd1);
    wait_done();
    check("t5_we_count", we_count - w0, 1);

    // Test 6: bytes in IDLE and a second start while busy are ignored.
    w0 = we_count;
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_not_ready", {63'd0, byte_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("t6_idle_no_we", we_count - w0, 0);
    exp_q.push_back('{a: 15'h0060, data: 32'hC0C1C2C3, sel: 4'b1111});
    do_start(15'h0060);
    send_byte(8'hC0, 1'b0);
    do_start(15'h0070);
    check("t6_addr_kept", {49'd0, addr}, 64'h0060);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b1);
    wait_done();
    check("t6_we_count", we_count - w0, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
